// File: rtl/dot3_mac_sequencer.sv
// dot3_mac_sequencer: y = x0*K0 + x1*K1 + x2*K2 over one shared external ALU.
// Six ALU cycles per sample set (MUL/ADD per tap); the block itself only sequences.
package cpu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_MUL = 4'd5
  } aluFunc_t;
endpackage

module dot3_mac_sequencer
  import cpu_pkg::*;
#(
  parameter int                      WIDTH = 8,
  parameter logic signed [WIDTH-1:0] K0    = WIDTH'(17),
  parameter logic signed [WIDTH-1:0] K1    = WIDTH'(29),
  parameter logic signed [WIDTH-1:0] K2    = WIDTH'(35)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output aluFunc_t         alu_func,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             live_q, live_d;
  logic [1:0]       tap_q, tap_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] x0_q, x0_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] x_sel, k_sel;
  logic             unused_flags;

  // Only the ADD-step overflow matters; MUL flags are meaningless here.
  assign unused_flags = ^alu_flags[3:1];

  always_comb begin
    x_sel = x2_q;
    k_sel = K2;
    case (tap_q)
      2'd0: begin
        x_sel = x0_q;
        k_sel = K0;
      end
      2'd1: begin
        x_sel = x1_q;
        k_sel = K1;
      end
      default: begin
        x_sel = x2_q;
        k_sel = K2;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    live_d    = 1'b1;
    tap_d     = tap_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    ovf_d     = ovf_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = ALU_ADD;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = live_q;
        if (live_q && in_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          x2_d    = x2;
          acc_d   = '0;
          ovf_d   = 1'b0;
          tap_d   = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        alu_a    = x_sel;
        alu_b    = k_sel;
        alu_func = ALU_MUL;
        prod_d   = alu_result;
        state_d  = ADD;
      end
      ADD: begin
        alu_a    = acc_q;
        alu_b    = prod_q;
        alu_func = ALU_ADD;
        acc_d    = alu_result;
        ovf_d    = ovf_q | alu_flags[0];
        if (tap_q == 2'd2) begin
          state_d = DONE;
        end else begin
          tap_d   = tap_q + 2'd1;
          state_d = MUL;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // y/ovf are exposed only in DONE so no partial sum ever leaks out.
  assign y   = (state_q == DONE) ? acc_q : '0;
  assign ovf = (state_q == DONE) ? ovf_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      tap_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dot3_mac_sequencer.sv
// tb_dot3_mac_sequencer: scoreboard bench, default-K and K=127 instances
// driven in lockstep, each with a behavioural 8-bit ALU.
module tb_dot3_mac_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_reset, in_valid, out_ready;
  logic [7:0] x0, x1, x2;

  logic       a_in_ready, a_out_valid, a_ovf;
  logic [7:0] a_y, a_alu_a, a_alu_b, a_alu_res;
  logic [3:0] a_alu_flg;
  aluFunc_t   a_alu_func;

  logic       b_in_ready, b_out_valid, b_ovf;
  logic [7:0] b_y, b_alu_a, b_alu_b, b_alu_res;
  logic [3:0] b_alu_flg;
  aluFunc_t   b_alu_func;

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] ea, eb;
  logic [7:0] sx[3];
  time        t_acc = 0;
  time        t_prev = 0;

  function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b,
                                         input aluFunc_t f);
    logic signed [15:0] p;
    logic signed [15:0] r;
    if (f == ALU_MUL) begin
      p = $signed(a) * $signed(b);
      r = p >>> 7;
      if (p < 0 && p[6:0] != 7'd0) r = r + 16'sd1;
      return r[7:0];
    end
    return a + b;
  endfunction

  function automatic logic [3:0] alu_flg(input logic [7:0] a, input logic [7:0] b,
                                         input aluFunc_t f);
    logic [7:0]         r;
    logic               v;
    logic signed [15:0] p;
    r = alu_res(a, b, f);
    if (f == ALU_MUL) begin
      p = $signed(a) * $signed(b);
      v = (p[6:0] != 7'd0);
    end else begin
      v = (a[7] == b[7]) && (r[7] != a[7]);
    end
    return {r[7], r == 8'd0, 1'b0, v};
  endfunction

  function automatic logic [8:0] dot(input logic [7:0] v0, input logic [7:0] v1,
                                     input logic [7:0] v2, input logic [7:0] k0,
                                     input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] xs[3];
    logic [7:0] ks[3];
    logic [7:0] acc, p;
    logic [3:0] f;
    logic       o;
    xs[0] = v0; xs[1] = v1; xs[2] = v2;
    ks[0] = k0; ks[1] = k1; ks[2] = k2;
    acc = 8'd0;
    o   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p   = alu_res(xs[i], ks[i], ALU_MUL);
      f   = alu_flg(acc, p, ALU_ADD);
      o   = o | f[0];
      acc = alu_res(acc, p, ALU_ADD);
    end
    return {o, acc};
  endfunction

  assign a_alu_res = alu_res(a_alu_a, a_alu_b, a_alu_func);
  assign a_alu_flg = alu_flg(a_alu_a, a_alu_b, a_alu_func);
  assign b_alu_res = alu_res(b_alu_a, b_alu_b, b_alu_func);
  assign b_alu_flg = alu_flg(b_alu_a, b_alu_b, b_alu_func);

  dot3_mac_sequencer u_dut_a (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .alu_a     (a_alu_a),
    .alu_b     (a_alu_b),
    .alu_func  (a_alu_func),
    .alu_result(a_alu_res),
    .alu_flags (a_alu_flg),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .y         (a_y),
    .ovf       (a_ovf)
  );

  dot3_mac_sequencer #(
    .K0(8'sd127),
    .K1(8'sd127),
    .K2(8'sd127)
  ) u_dut_b (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .alu_a     (b_alu_a),
    .alu_b     (b_alu_b),
    .alu_func  (b_alu_func),
    .alu_result(b_alu_res),
    .alu_flags (b_alu_flg),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .y         (b_y),
    .ovf       (b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
    int n = 0;
    x0       = v0;
    x1       = v1;
    x2       = v2;
    in_valid = 1'b1;
    while (!a_in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready", a_in_ready, 1);
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = $time;
    qa.push_back(dot(v0, v1, v2, 8'd17, 8'd29, 8'd35));
    qb.push_back(dot(v0, v1, v2, 8'd127, 8'd127, 8'd127));
    sx[0] = v0; sx[1] = v1; sx[2] = v2;
    #1;
    in_valid = 1'b0;
    x0 = 8'($urandom);
    x1 = 8'($urandom);
    x2 = 8'($urandom);
  endtask

  // Called one cycle after the accept edge; ends in the DONE cycle.
  task automatic track();
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] ka[3];
    ka[0] = 8'd17; ka[1] = 8'd29; ka[2] = 8'd35;
    acc = 8'd0;
    for (int i = 0; i < 3; i++) begin
      p = alu_res(sx[i], ka[i], ALU_MUL);
      chk("bus_mul_f", a_alu_func, ALU_MUL);
      chk("bus_mul_a", a_alu_a, sx[i]);
      chk("bus_mul_b", a_alu_b, ka[i]);
      chk("busy_ready", a_in_ready, 0);
      step();
      chk("bus_add_f", a_alu_func, ALU_ADD);
      chk("bus_add_a", a_alu_a, acc);
      chk("bus_add_b", a_alu_b, p);
      chk("busy_valid", a_out_valid, 0);
      acc = alu_res(acc, p, ALU_ADD);
      step();
    end
    chk("out_valid_lat", a_out_valid, 1);
    chk("b_out_valid_lat", b_out_valid, 1);
    chk("done_ready", a_in_ready, 0);
    chk("idle_f", a_alu_func, ALU_ADD);
    chk("idle_a", a_alu_a, 0);
    chk("idle_b", a_alu_b, 0);
  endtask

  always @(negedge clk) begin
    if (n_reset === 1'b1 && a_out_valid && out_ready) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        chk("sb_underflow", 32'(qa.size()), 1);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_y", a_y, ea[7:0]);
        chk("a_ovf", a_ovf, ea[8]);
        chk("b_y", b_y, eb[7:0]);
        chk("b_ovf", b_ovf, eb[8]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x0 = 8'd0;
    x1 = 8'd0;
    x2 = 8'd0;
    step();
    step();
    chk("rst_valid", a_out_valid, 0);
    chk("rst_y", a_y, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_ready", a_in_ready, 0);
    chk("rst_func", a_alu_func, ALU_ADD);
    n_reset = 1'b1;
    step();
    chk("rel_ready", a_in_ready, 1);

    send(8'd64, 8'd64, 8'd64);
    track();
    step();
    send(8'h80, 8'h80, 8'h80);
    chk("throughput", 32'((t_acc - t_prev) / 10), 8);
    track();
    step();

    send(8'd127, 8'd127, 8'd127);
    track();
    step();
    send(8'd0, 8'd0, 8'd0);
    track();
    step();

    out_ready = 1'b0;
    send(8'h90, 8'h20, 8'h7f);
    track();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_ready", a_in_ready, 0);
      chk("bp_y", a_y, qa[0][7:0]);
      chk("bp_ovf", a_ovf, qa[0][8]);
      chk("bp_b_y", b_y, qb[0][7:0]);
      chk("bp_b_ovf", b_ovf, qb[0][8]);
      if (i == 1) begin
        in_valid = 1'b1;
        x0 = 8'd5;
        x1 = 8'd5;
        x2 = 8'd5;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_valid", a_out_valid, 0);
    chk("post_ready", a_in_ready, 1);
    send(8'd3, 8'hfd, 8'd100);
    track();
    step();

    send(8'd10, 8'd20, 8'd30);
    step();
    step();
    step();
    n_reset = 1'b0;
    step();
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_ovf", a_ovf, 0);
    chk("mid_rst_ready", a_in_ready, 0);
    chk("mid_rst_func", a_alu_func, ALU_ADD);
    qa.delete();
    qb.delete();
    n_reset = 1'b1;
    step();
    chk("mid_rel_ready", a_in_ready, 1);

    send(8'hc0, 8'h40, 8'hff);
    track();
    step();
    chk("sb_drain", 32'(qa.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
